ps2_key_rx: RTL and testbench
=============================

PS2_KEY_RX -- requirements
Module: ps2_key_rx

Interface
REQ-001 SHALL have parameter TIMEOUT, default 10000, meaning the maximum clk_sys cycles between ps2_clk falling edges inside a frame.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth on ps2_clk and ps2_dat.
REQ-003 clk_sys  input  1  single system clock; all logic on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 ps2_clk  input  1  raw PS/2 clock line, asynchronous, idles high.
REQ-006 ps2_dat  input  1  raw PS/2 data line, asynchronous, idles high.
REQ-007 ps2_key  output  11  [10] toggles per key event, [9] 1=pressed/0=released, [8] E0-extended, [7:0] scan code.
REQ-008 frame_err  output  1  one-cycle pulse on a rejected or timed-out frame.

Function
REQ-009 Both lines SHALL pass through SYNC_STAGES flops; a falling edge is synced ps2_clk previous=1, current=0.
REQ-010 Frame format SHALL be: start 0, 8 data bits LSB first, odd parity, stop 1; every bit sampled on the falling-edge cycle.
REQ-011 Deframer states SHALL be IDLE, DATA, PARITY, STOP; IDLE->DATA on a falling edge with data=0; a falling edge with data=1 in IDLE is ignored without error.
REQ-012 DATA SHALL shift 8 bits using a 3-bit counter, then go to PARITY; PARITY captures one bit and goes to STOP; STOP always returns to IDLE.
REQ-013 In STOP, data=1 with valid parity SHALL assert internal byte_valid for one cycle, one cycle after the stop-bit edge; otherwise frame_err pulses and no byte is produced.
REQ-014 Outside IDLE, the timeout counter SHALL clear on every falling edge; on reaching TIMEOUT it forces IDLE and pulses frame_err; in IDLE it holds at 0.
REQ-015 Decoder: byte 0xE0 SHALL set ext; byte 0xF0 SHALL set brk; neither updates ps2_key.
REQ-016 Bytes 0xFA, 0xAA, 0xEE, 0xFE, 0x00, 0xFF SHALL be discarded: ps2_key unchanged, ext/brk unchanged.
REQ-017 Any other byte b SHALL load ps2_key <= {~ps2_key[10], ~brk, ext, b} on the cycle after byte_valid and clear ext and brk on that same cycle.
REQ-018 Total latency from stop-bit falling-edge detection to ps2_key update SHALL be 2 clk_sys cycles.
REQ-019 A frame_err SHALL clear ext and brk.
REQ-020 A falling edge coincident with timeout expiry SHALL be treated as the timeout: IDLE, frame_err, edge discarded.
REQ-021 ps2_key SHALL hold its value indefinitely between events; bit 10 wraps 1->0 normally.

Reset
REQ-022 On reset_n=0: ps2_key=11'h000, frame_err=0, state IDLE, counters 0, ext=brk=0, synchronizer flops=1 (no false edge at release).
REQ-023 Reset mid-frame SHALL abandon the frame; the first complete frame after release SHALL decode correctly.

Configuration
REQ-024 With PS2_KEY_RX_PARITY_EN defined, a parity mismatch SHALL reject the frame per REQ-013.
REQ-025 Without PS2_KEY_RX_PARITY_EN, the parity bit SHALL be sampled and ignored; only start/stop bits and timeout cause frame_err.

Structure
REQ-026 Package ps2_key_pkg SHALL hold the deframer state enum, prefix constants 0xE0/0xF0, the discard-code list, and ps2_key bit-index constants.
REQ-027 Sub-module ps2_frame_rx SHALL contain synchronizer, edge detect, deframer and timeout; ps2_key_rx adds the prefix decoder and output register.

Verification
REQ-028 Reset, then frame 0x1C -> ps2_key 0x000 -> 0x61C exactly 2 cycles after the stop-bit edge; frame_err stays 0.
REQ-029 Frames F0,1C after REQ-028 -> single update to 0x01C; no update after the F0 frame.
REQ-030 Frames E0,75 then E0,F0,75 -> ps2_key 0x775, then 0x175.
REQ-031 Frame 0x1C with wrong parity -> with macro: frame_err one-cycle pulse, ps2_key unchanged; without macro: ps2_key toggles and updates to code 0x1C.
REQ-032 Start plus 5 data bits, then lines idle 2*TIMEOUT cycles -> one frame_err pulse at TIMEOUT; a following 0x29 frame decodes normally.
REQ-033 Frame 0xFA, and separately reset_n low mid-frame, -> ps2_key unchanged / 0x000, respectively; the next 0x16 frame decodes correctly.

Source files
------------

// File: rtl/ps2_key_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver: deframer states,
// prefix codes, discarded controller replies and ps2_key bit positions.
package ps2_key_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rxState_t;

   localparam logic [7:0] PREFIX_EXT = 8'hE0;
   localparam logic [7:0] PREFIX_BRK = 8'hF0;

   // Keyboard replies and error codes that never represent a key
   localparam int NUM_DISCARD = 6;
   localparam logic [NUM_DISCARD*8-1:0] DISCARD_CODES =
      {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

   localparam int KEY_TOGGLE_BIT = 10;
   localparam int KEY_PRESS_BIT  = 9;
   localparam int KEY_EXT_BIT    = 8;
   localparam int KEY_CODE_MSB   = 7;

   function automatic logic isDiscard(input logic [7:0] code);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < NUM_DISCARD; i++) begin
         if (code == DISCARD_CODES[i*8 +: 8]) begin
            hit = 1'b1;
         end
      end
      return hit;
   endfunction

endpackage

// File: rtl/ps2_key_rx_if.sv
// Bundle of the PS/2 line inputs and the decoded key outputs of ps2_key_rx.
interface ps2_key_rx_if;

   logic        ps2_clk;
   logic        ps2_dat;
   logic [10:0] ps2_key;
   logic        frame_err;

   modport slave (
      input  ps2_clk,
      input  ps2_dat,
      output ps2_key,
      output frame_err
   );

   modport master (
      output ps2_clk,
      output ps2_dat,
      input  ps2_key,
      input  frame_err
   );

endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 line synchronizer, falling-edge detector, 11-bit deframer and timeout.
// Define PS2_KEY_RX_PARITY_EN to reject frames whose odd parity is wrong.
module ps2_frame_rx
   import ps2_key_pkg::*;
#(
   parameter int TIMEOUT     = 10000,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       i_ps2Clk,
   input  logic       i_ps2Dat,
   output logic       o_byteValid,
   output logic [7:0] o_byte,
   output logic       o_frameErr
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [SYNC_STAGES-1:0] r_clkSync;
   logic [SYNC_STAGES-1:0] r_datSync;
   logic                   r_clkPrev;
   rxState_t               r_state;
   logic [2:0]             r_bitCnt;
   logic [7:0]             r_shift;
   logic [CNT_W-1:0]       r_toCnt;
   logic                   r_byteValid;
   logic                   r_frameErr;
`ifdef PS2_KEY_RX_PARITY_EN
   logic                   r_parity;
`endif

   logic w_clkNow;
   logic w_dat;
   logic w_fall;
   logic w_timeout;
   logic w_parityOk;

   // Flops reset high so releasing reset never looks like a clock edge
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_clkSync <= '1;
         r_datSync <= '1;
         r_clkPrev <= 1'b1;
      end else begin
         r_clkSync[0] <= i_ps2Clk;
         r_datSync[0] <= i_ps2Dat;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_clkSync[i] <= r_clkSync[i-1];
            r_datSync[i] <= r_datSync[i-1];
         end
         r_clkPrev <= w_clkNow;
      end
   end

   assign w_clkNow  = r_clkSync[SYNC_STAGES-1];
   assign w_dat     = r_datSync[SYNC_STAGES-1];
   assign w_fall    = r_clkPrev & ~w_clkNow;
   assign w_timeout = (r_state != ST_IDLE) && (r_toCnt == CNT_W'(TIMEOUT));

`ifdef PS2_KEY_RX_PARITY_EN
   assign w_parityOk = ^{r_shift, r_parity};
`else
   assign w_parityOk = 1'b1;
`endif

   // Timeout wins over a coincident edge; the edge is simply dropped
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_bitCnt    <= 3'd0;
         r_shift     <= 8'h00;
         r_toCnt     <= '0;
         r_byteValid <= 1'b0;
         r_frameErr  <= 1'b0;
`ifdef PS2_KEY_RX_PARITY_EN
         r_parity    <= 1'b0;
`endif
      end else begin
         r_byteValid <= 1'b0;
         r_frameErr  <= 1'b0;
         if (w_timeout) begin
            r_state    <= ST_IDLE;
            r_toCnt    <= '0;
            r_frameErr <= 1'b1;
         end else begin
            r_toCnt <= (r_state == ST_IDLE || w_fall) ? '0 : r_toCnt + 1'b1;
            if (w_fall) begin
               case (r_state)
                  ST_IDLE: begin
                     if (!w_dat) begin
                        r_state  <= ST_DATA;
                        r_bitCnt <= 3'd0;
                     end
                  end
                  ST_DATA: begin
                     r_shift  <= {w_dat, r_shift[7:1]};
                     r_bitCnt <= r_bitCnt + 3'd1;
                     if (r_bitCnt == 3'd7) begin
                        r_state <= ST_PARITY;
                     end
                  end
                  ST_PARITY: begin
`ifdef PS2_KEY_RX_PARITY_EN
                     r_parity <= w_dat;
`endif
                     r_state  <= ST_STOP;
                  end
                  ST_STOP: begin
                     r_state <= ST_IDLE;
                     if (w_dat && w_parityOk) begin
                        r_byteValid <= 1'b1;
                     end else begin
                        r_frameErr <= 1'b1;
                     end
                  end
                  default: r_state <= ST_IDLE;
               endcase
            end
         end
      end
   end

   assign o_byteValid = r_byteValid;
   assign o_byte      = r_shift;
   assign o_frameErr  = r_frameErr;

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: deframes bytes and folds E0/F0 prefixes into ps2_key.
// Define PS2_KEY_RX_PARITY_EN to reject frames whose odd parity is wrong.
module ps2_key_rx
   import ps2_key_pkg::*;
#(
   parameter int TIMEOUT     = 10000,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk_sys,
   input  logic         reset_n,
   ps2_key_rx_if.slave  bus
);

   logic        w_byteValid;
   logic [7:0]  w_byte;
   logic        w_frameErr;

   logic [10:0] r_key;
   logic        r_ext;
   logic        r_brk;

   ps2_frame_rx #(
      .TIMEOUT     (TIMEOUT),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_frameRx (
      .clk_sys     (clk_sys),
      .reset_n     (reset_n),
      .i_ps2Clk    (bus.ps2_clk),
      .i_ps2Dat    (bus.ps2_dat),
      .o_byteValid (w_byteValid),
      .o_byte      (w_byte),
      .o_frameErr  (w_frameErr)
   );

   // A bad frame may have eaten the key that a pending prefix belonged to
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_key <= 11'h000;
         r_ext <= 1'b0;
         r_brk <= 1'b0;
      end else if (w_frameErr) begin
         r_ext <= 1'b0;
         r_brk <= 1'b0;
      end else if (w_byteValid) begin
         if (w_byte == PREFIX_EXT) begin
            r_ext <= 1'b1;
         end else if (w_byte == PREFIX_BRK) begin
            r_brk <= 1'b1;
         end else if (!isDiscard(w_byte)) begin
            r_key[KEY_TOGGLE_BIT]   <= ~r_key[KEY_TOGGLE_BIT];
            r_key[KEY_PRESS_BIT]    <= ~r_brk;
            r_key[KEY_EXT_BIT]      <= r_ext;
            r_key[KEY_CODE_MSB:0]   <= w_byte;
            r_ext                   <= 1'b0;
            r_brk                   <= 1'b0;
         end
      end
   end

   assign bus.ps2_key   = r_key;
   assign bus.frame_err = w_frameErr;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Scoreboard bench for ps2_key_rx: stimulus pushes expected key updates and
// frame errors, an independent monitor pops them as the DUT produces them.
`timescale 1ns/1ps
module tb_ps2_key_rx;

   localparam int TIMEOUT     = 200;
   localparam int SYNC_STAGES = 2;
   localparam int HALF        = 10;

   typedef struct {
      logic [10:0] key;
      int          cyc;
   } keyExp_t;

   typedef struct {
      int lo;
      int hi;
   } errExp_t;

   logic    clk_sys = 1'b0;
   logic    reset_n = 1'b0;
   int      cyc     = 0;
   int      checks  = 0;
   int      passed  = 0;
   keyExp_t keyQ[$];
   errExp_t errQ[$];
   keyExp_t keyItem;
   errExp_t errItem;
   logic [10:0] lastKey = 11'h000;
   bit      prevErr = 1'b0;

   ps2_key_rx_if bus ();

   ps2_key_rx #(
      .TIMEOUT     (TIMEOUT),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // One device-driven bit: data settles while the clock is high, then it falls
   task automatic driveBit(input logic b, output int edgeCyc);
      @(negedge clk_sys);
      bus.ps2_dat = b;
      repeat (HALF) @(negedge clk_sys);
      bus.ps2_clk = 1'b0;
      edgeCyc = cyc;
      repeat (HALF) @(negedge clk_sys);
      bus.ps2_clk = 1'b1;
   endtask

   task automatic applyStimulus(input logic [7:0] b, input bit badPar, input bit expUpd,
                                input logic [10:0] expKey, input bit expErr);
      int   c;
      logic par;
      par = (~^b) ^ badPar;
      driveBit(1'b0, c);
      for (int i = 0; i < 8; i++) driveBit(b[i], c);
      driveBit(par, c);
      @(negedge clk_sys);
      bus.ps2_dat = 1'b1;
      repeat (HALF) @(negedge clk_sys);
      bus.ps2_clk = 1'b0;
      c = cyc;
      if (expUpd) keyQ.push_back('{key: expKey, cyc: c + SYNC_STAGES + 2});
      if (expErr) errQ.push_back('{lo: c + SYNC_STAGES + 1, hi: c + SYNC_STAGES + 1});
      repeat (HALF) @(negedge clk_sys);
      bus.ps2_clk = 1'b1;
      repeat (30) @(negedge clk_sys);
   endtask

   task automatic sendPartial(input logic [7:0] b, input int nBits, output int lastEdge);
      driveBit(1'b0, lastEdge);
      for (int i = 0; i < nBits; i++) driveBit(b[i], lastEdge);
   endtask

   always @(negedge clk_sys) begin
      if (!reset_n) begin
         lastKey = bus.ps2_key;
         prevErr = 1'b0;
      end else begin
         if (bus.ps2_key !== lastKey) begin
            if (keyQ.size() == 0) begin
               checkOutput("unexpectedKey", {21'd0, bus.ps2_key}, {21'd0, lastKey});
            end else begin
               keyItem = keyQ.pop_front();
               checkOutput("keyValue", {21'd0, bus.ps2_key}, {21'd0, keyItem.key});
               checkOutput("keyLatency", cyc, keyItem.cyc);
            end
            lastKey = bus.ps2_key;
         end
         if (prevErr) begin
            checkOutput("errWidth", {31'd0, bus.frame_err}, 32'd0);
            prevErr = 1'b0;
         end else if (bus.frame_err) begin
            if (errQ.size() == 0) begin
               checkOutput("unexpectedErr", {31'd0, bus.frame_err}, 32'd0);
            end else begin
               errItem = errQ.pop_front();
               checkOutput("errTiming", {31'd0, (cyc >= errItem.lo && cyc <= errItem.hi)}, 32'd1);
            end
            prevErr = 1'b1;
         end
      end
   end

   initial begin
      int c;
      bus.ps2_clk = 1'b1;
      bus.ps2_dat = 1'b1;
      reset_n     = 1'b0;
      repeat (5) @(negedge clk_sys);
      checkOutput("resetKey", {21'd0, bus.ps2_key}, 32'h000);
      checkOutput("resetErr", {31'd0, bus.frame_err}, 32'd0);
      reset_n = 1'b1;
      repeat (10) @(negedge clk_sys);

      applyStimulus(8'h1C, 1'b0, 1'b1, 11'h61C, 1'b0);
      applyStimulus(8'hF0, 1'b0, 1'b0, 11'h000, 1'b0);
      applyStimulus(8'h1C, 1'b0, 1'b1, 11'h01C, 1'b0);
      applyStimulus(8'hE0, 1'b0, 1'b0, 11'h000, 1'b0);
      applyStimulus(8'h75, 1'b0, 1'b1, 11'h775, 1'b0);
      applyStimulus(8'hE0, 1'b0, 1'b0, 11'h000, 1'b0);
      applyStimulus(8'hF0, 1'b0, 1'b0, 11'h000, 1'b0);
      applyStimulus(8'h75, 1'b0, 1'b1, 11'h175, 1'b0);

`ifdef PS2_KEY_RX_PARITY_EN
      applyStimulus(8'h1C, 1'b1, 1'b0, 11'h000, 1'b1);
`else
      applyStimulus(8'h1C, 1'b1, 1'b1, 11'h61C, 1'b0);
`endif

      sendPartial(8'h5A, 5, c);
      errQ.push_back('{lo: c + TIMEOUT, hi: c + TIMEOUT + SYNC_STAGES + 8});
      repeat (2 * TIMEOUT) @(negedge clk_sys);

`ifdef PS2_KEY_RX_PARITY_EN
      applyStimulus(8'h29, 1'b0, 1'b1, 11'h629, 1'b0);
      applyStimulus(8'hFA, 1'b0, 1'b0, 11'h000, 1'b0);
      applyStimulus(8'h16, 1'b0, 1'b1, 11'h216, 1'b0);
`else
      applyStimulus(8'h29, 1'b0, 1'b1, 11'h229, 1'b0);
      applyStimulus(8'hFA, 1'b0, 1'b0, 11'h000, 1'b0);
      applyStimulus(8'h16, 1'b0, 1'b1, 11'h616, 1'b0);
`endif

      sendPartial(8'h16, 3, c);
      @(negedge clk_sys);
      reset_n = 1'b0;
      repeat (3) @(negedge clk_sys);
      checkOutput("midResetKey", {21'd0, bus.ps2_key}, 32'h000);
      checkOutput("midResetErr", {31'd0, bus.frame_err}, 32'd0);
      reset_n = 1'b1;
      repeat (10) @(negedge clk_sys);
      applyStimulus(8'h16, 1'b0, 1'b1, 11'h616, 1'b0);

      repeat (20) @(negedge clk_sys);
      checkOutput("keyQueueEmpty", keyQ.size(), 32'd0);
      checkOutput("errQueueEmpty", errQ.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
